// File: rtl/pipeline_control.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes and
// multi-cycle EX occupancy, with registered active-low stage clears.
module pipeline_control #(
  parameter int MC_CYCLES  = 4,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  idex_we,
  output logic                  exmem_we,
  output logic                  memwb_we,
  output logic                  ifid_flush_n,
  output logic                  idex_flush_n,
  output logic                  exmem_flush_n,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MC_BUSY    = 2'd3
  } state_t;

  state_t     state, nxt;
  logic [3:0] mc_cnt, cnt_nxt;
  logic       mc_done, done_nxt;
  logic       hz1, hz2, load_use, mc_go;
  logic [4:0] en;

  assign hz1      = id_use_rs1 && (ex_rd == id_rs1);
  assign hz2      = id_use_rs2 && (ex_rd == id_rs2);
  assign load_use = ex_mem_read && (ex_rd != '0) && (hz1 || hz2);
  assign mc_go    = ex_mc_start && !mc_done;

  // en = {pc, ifid, idex, exmem, memwb}
  always_comb begin
    nxt      = state;
    cnt_nxt  = mc_cnt;
    done_nxt = 1'b0;
    en       = 5'b11111;
    unique case (state)
      RUN: begin
        if (ex_branch_taken) begin
          nxt = FLUSH;
        end else if (mc_go) begin
          en      = 5'b00011;
          cnt_nxt = 4'(MC_CYCLES - 2);
          nxt     = MC_BUSY;
        end else if (load_use) begin
          en  = 5'b00111;
          nxt = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        en  = 5'b00111;
        nxt = RUN;
      end
      FLUSH: begin
        en  = 5'b01111;
        nxt = RUN;
      end
      MC_BUSY: begin
        en = 5'b00011;
        if (mc_cnt == 4'd0) begin
          nxt      = RUN;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = mc_cnt - 4'd1;
        end
      end
      default: nxt = RUN;
    endcase
  end

  assign {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = reset ? en : 5'b0;
  assign busy      = reset && (state != RUN);
  assign state_dbg = state;

  // Clears come straight from flops so downstream stages see glitch-free lows
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= RUN;
      mc_cnt        <= 4'd0;
      mc_done       <= 1'b0;
      ifid_flush_n  <= 1'b0;
      idex_flush_n  <= 1'b0;
      exmem_flush_n <= 1'b0;
    end else begin
      state         <= nxt;
      mc_cnt        <= cnt_nxt;
      mc_done       <= done_nxt;
      ifid_flush_n  <= (nxt != FLUSH);
      idex_flush_n  <= !((nxt == FLUSH) || (nxt == LOAD_STALL));
      exmem_flush_n <= (nxt != MC_BUSY);
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control at MC_CYCLES = 4, 2 and 8.
module tb_pipeline_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read;
  logic       ex_branch_taken, ex_mc_start;

  logic [4:0] en4, en2, en8;
  logic [2:0] fl4, fl2, fl8;
  logic       bz4, bz2, bz8;
  logic [1:0] st4, st2, st8;

  // obs = {state_dbg, busy, pc/ifid/idex/exmem/memwb we, ifid/idex/exmem flush_n}
  logic [10:0] obs4, obs2, obs8;
  assign obs4 = {st4, bz4, en4, fl4};
  assign obs2 = {st2, bz2, en2, fl2};
  assign obs8 = {st8, bz8, en8, fl8};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_control #(.MC_CYCLES(4), .REG_ADDR_W(4)) u4 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
    .pc_we(en4[4]), .ifid_we(en4[3]), .idex_we(en4[2]),
    .exmem_we(en4[1]), .memwb_we(en4[0]),
    .ifid_flush_n(fl4[2]), .idex_flush_n(fl4[1]), .exmem_flush_n(fl4[0]),
    .busy(bz4), .state_dbg(st4)
  );

  pipeline_control #(.MC_CYCLES(2), .REG_ADDR_W(4)) u2 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
    .pc_we(en2[4]), .ifid_we(en2[3]), .idex_we(en2[2]),
    .exmem_we(en2[1]), .memwb_we(en2[0]),
    .ifid_flush_n(fl2[2]), .idex_flush_n(fl2[1]), .exmem_flush_n(fl2[0]),
    .busy(bz2), .state_dbg(st2)
  );

  pipeline_control #(.MC_CYCLES(8), .REG_ADDR_W(4)) u8 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
    .pc_we(en8[4]), .ifid_we(en8[3]), .idex_we(en8[2]),
    .exmem_we(en8[1]), .memwb_we(en8[0]),
    .ifid_flush_n(fl8[2]), .idex_flush_n(fl8[1]), .exmem_flush_n(fl8[0]),
    .busy(bz8), .state_dbg(st8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rd = 4'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_00000_000) begin
      n_err++;
      $display("FAIL reset_edge1 got %b want %b", obs4, 11'b00_0_00000_000);
    end
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_00000_000) begin
      n_err++;
      $display("FAIL reset_edge2 got %b want %b", obs4, 11'b00_0_00000_000);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_000) begin
      n_err++;
      $display("FAIL reset_release got %b want %b", obs4, 11'b00_0_11111_000);
    end
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL reset_run got %b want %b", obs4, 11'b00_0_11111_111);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs2 = 4'd3; id_use_rs2 = 1'b1;
    #1;
    n_cmp++;
    if (obs4 !== 11'b00_0_00111_111) begin
      n_err++;
      $display("FAIL lu_detect got %b want %b", obs4, 11'b00_0_00111_111);
    end
    tick();
    clr_in();
    #1;
    n_cmp++;
    if (obs4 !== 11'b01_1_00111_101) begin
      n_err++;
      $display("FAIL lu_stall got %b want %b", obs4, 11'b01_1_00111_101);
    end
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL lu_resume got %b want %b", obs4, 11'b00_0_11111_111);
    end
    ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs2 = 4'd0; id_use_rs2 = 1'b1;
    id_rs1 = 4'd0; id_use_rs1 = 1'b1;
    #1;
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL lu_reg0 got %b want %b", obs4, 11'b00_0_11111_111);
    end
    tick();
    clr_in();
    ex_mem_read = 1'b1; ex_rd = 4'd5; id_rs1 = 4'd5; id_use_rs1 = 1'b0;
    #1;
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL lu_unused got %b want %b", obs4, 11'b00_0_11111_111);
    end
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL lu_nostall got %b want %b", obs4, 11'b00_0_11111_111);
    end
    id_use_rs1 = 1'b1;
    #1;
    n_cmp++;
    if (obs4 !== 11'b00_0_00111_111) begin
      n_err++;
      $display("FAIL lu_rs1 got %b want %b", obs4, 11'b00_0_00111_111);
    end
    tick();
    clr_in();
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1'b1; ex_mc_start = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs1 = 4'd3; id_use_rs1 = 1'b1;
    #1;
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL br_taken got %b want %b", obs4, 11'b00_0_11111_111);
    end
    tick();
    n_cmp++;
    if (obs4 !== 11'b10_1_01111_001) begin
      n_err++;
      $display("FAIL br_flush got %b want %b", obs4, 11'b10_1_01111_001);
    end
    clr_in();
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL br_resume got %b want %b", obs4, 11'b00_0_11111_111);
    end
  endtask

  task automatic test_mc4();
    do_reset();
    ex_mc_start = 1'b1;
    #1;
    n_cmp++;
    if (obs4 !== 11'b00_0_00011_111) begin
      n_err++;
      $display("FAIL mc4_start got %b want %b", obs4, 11'b00_0_00011_111);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_branch_taken = (i == 1);
      #1;
      n_cmp++;
      if (obs4 !== 11'b11_1_00011_110) begin
        n_err++;
        $display("FAIL mc4_busy%0d got %b want %b", i, obs4, 11'b11_1_00011_110);
      end
    end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL mc4_done got %b want %b", obs4, 11'b00_0_11111_111);
    end
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_00011_111) begin
      n_err++;
      $display("FAIL mc4_retrig got %b want %b", obs4, 11'b00_0_00011_111);
    end
    clr_in();
    do_reset();
  endtask

  task automatic test_mc2();
    do_reset();
    ex_mc_start = 1'b1;
    #1;
    n_cmp++;
    if (obs2 !== 11'b00_0_00011_111) begin
      n_err++;
      $display("FAIL mc2_start got %b want %b", obs2, 11'b00_0_00011_111);
    end
    tick();
    n_cmp++;
    if (obs2 !== 11'b11_1_00011_110) begin
      n_err++;
      $display("FAIL mc2_busy got %b want %b", obs2, 11'b11_1_00011_110);
    end
    tick();
    n_cmp++;
    if (obs2 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL mc2_done got %b want %b", obs2, 11'b00_0_11111_111);
    end
    tick();
    n_cmp++;
    if (obs2 !== 11'b00_0_00011_111) begin
      n_err++;
      $display("FAIL mc2_retrig got %b want %b", obs2, 11'b00_0_00011_111);
    end
    clr_in();
  endtask

  task automatic test_mc8_reset();
    do_reset();
    ex_mc_start = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs8 !== 11'b11_1_00011_110) begin
      n_err++;
      $display("FAIL mc8_busy2 got %b want %b", obs8, 11'b11_1_00011_110);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs8 !== 11'b11_0_00000_110) begin
      n_err++;
      $display("FAIL mc8_rst_comb got %b want %b", obs8, 11'b11_0_00000_110);
    end
    tick();
    n_cmp++;
    if (obs8 !== 11'b00_0_00000_000) begin
      n_err++;
      $display("FAIL mc8_rst_edge got %b want %b", obs8, 11'b00_0_00000_000);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs8 !== 11'b00_0_00011_000) begin
      n_err++;
      $display("FAIL mc8_fresh got %b want %b", obs8, 11'b00_0_00011_000);
    end
    tick();
    n_cmp++;
    if (obs8 !== 11'b11_1_00011_110) begin
      n_err++;
      $display("FAIL mc8_busy_again got %b want %b", obs8, 11'b11_1_00011_110);
    end
    clr_in();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    ex_mem_read = 1'b1; ex_rd = 4'd7; id_rs1 = 4'd7; id_use_rs1 = 1'b1;
    #1;
    n_cmp++;
    if (obs4 !== 11'b10_1_01111_001) begin
      n_err++;
      $display("FAIL b2b_flush got %b want %b", obs4, 11'b10_1_01111_001);
    end
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_00111_111) begin
      n_err++;
      $display("FAIL b2b_lu got %b want %b", obs4, 11'b00_0_00111_111);
    end
    tick();
    n_cmp++;
    if (obs4 !== 11'b01_1_00111_101) begin
      n_err++;
      $display("FAIL b2b_stall got %b want %b", obs4, 11'b01_1_00111_101);
    end
    clr_in();
    tick();
    n_cmp++;
    if (obs4 !== 11'b00_0_11111_111) begin
      n_err++;
      $display("FAIL b2b_run got %b want %b", obs4, 11'b00_0_11111_111);
    end
  endtask

  initial begin
    reset = 1'b0;
    clr_in();
    test_reset();
    test_load_use();
    test_branch();
    test_mc4();
    test_mc2();
    test_mc8_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
